fft_frame_feeder: RTL and testbench
===================================

FFT_FRAME_FEEDER -- requirements
Module: fft_frame_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of each real/imaginary word (IEEE-754 single when 32).
REQ-002 SHALL have parameter VEC_LEN, default 8, meaning samples per FFT frame.
REQ-003 SHALL have parameter DONE_TIMEOUT, default 1000, meaning maximum cycles to wait for FFT done after the last beat.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, ports as below.
REQ-005 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 s_valid  input  1  upstream sample valid.
REQ-008 s_ready  output  1  feeder can accept a sample this cycle.
REQ-009 s_re  input  DATA_W  upstream sample real part.
REQ-010 s_im  input  DATA_W  upstream sample imaginary part.
REQ-011 o_start  output  1  one-cycle frame-start pulse to the FFT's i_start.
REQ-012 o_valid  output  1  sample beat valid to the FFT's i_valid.
REQ-013 o_re  output  DATA_W  sample real part to the FFT's i_re.
REQ-014 o_im  output  DATA_W  sample imaginary part to the FFT's i_im.
REQ-015 i_fft_done  input  1  FFT o_done, frame complete.
REQ-016 o_err  output  1  sticky done-timeout flag.
REQ-017 o_frame_cnt  output  16  frames completed with done.

Function
REQ-018 SHALL buffer 2*VEC_LEN samples as a circular FIFO; write/read pointers wrap modulo 2*VEC_LEN; occupancy counter ranges 0..2*VEC_LEN.
REQ-019 A sample SHALL be accepted when s_valid && s_ready; s_ready = (occupancy < 2*VEC_LEN), combinational from registered occupancy.
REQ-020 FSM states SHALL be IDLE, START, GAP, SEND, WAIT_DONE.
REQ-021 IDLE -> START when occupancy >= VEC_LEN, evaluated on the registered occupancy; otherwise IDLE persists.
REQ-022 START lasts exactly 1 cycle with o_start=1, o_valid=0; then GAP.
REQ-023 GAP lasts exactly 1 cycle with o_start=0, o_valid=0; then SEND.
REQ-024 SEND SHALL emit exactly VEC_LEN consecutive beats, o_valid=1, in FIFO order, with no bubbles; a beat counter runs 0..VEC_LEN-1; then WAIT_DONE.
REQ-025 Each beat's read SHALL decrement occupancy by 1; a simultaneous accept and read SHALL leave occupancy unchanged.
REQ-026 o_re/o_im SHALL be registered and SHALL be 0 in every cycle in which o_valid=0.
REQ-027 WAIT_DONE -> IDLE on i_fft_done=1; o_frame_cnt SHALL increment by 1, wrapping from 0xFFFF to 0.
REQ-028 WAIT_DONE SHALL count cycles; when the count reaches DONE_TIMEOUT without done, o_err SHALL be set to 1 and remain set; the FSM SHALL go to IDLE; o_frame_cnt SHALL not increment.
REQ-029 i_fft_done SHALL be ignored outside WAIT_DONE.
REQ-030 Upstream acceptance SHALL continue in all states while s_ready=1, so that the next frame is buffered during SEND/WAIT_DONE.
REQ-031 Latency: if the VEC_LEN-th sample of a frame is accepted at edge T while the FSM is in IDLE, o_start SHALL be high in cycle T+2, and beats SHALL occur in cycles T+4..T+3+VEC_LEN.
REQ-032 Done in the same cycle as a full second frame: the FSM SHALL go to IDLE, then START on the following edge.

Reset
REQ-033 On i_rst_n=0, asynchronously: FSM=IDLE; pointers, occupancy, and beat and timeout counters=0; o_start=0; o_valid=0; o_re=o_im=0; o_err=0; o_frame_cnt=0. s_ready therefore reads 1.
REQ-034 Reset asserted mid-SEND or mid-WAIT_DONE SHALL discard all buffered samples; no partial frame SHALL resume after release.
REQ-035 The first sample acceptance SHALL be possible on the first rising edge after i_rst_n is released.

Verification
REQ-036 Single frame: feed samples 1.0..8.0 (0x3F800000..0x41000000), imaginary part 0, then done 5 cycles after the last beat -> o_start pulse once, one gap cycle, 8 beats in order, o_frame_cnt=1, o_err=0.
REQ-037 Back-to-back: stream 16 samples continuously with s_valid=1 -> s_ready stays 1 until occupancy reaches 16; the second frame starts 1 cycle after done; outputs match the input order.
REQ-038 Full buffer: 24 samples offered with done withheld -> s_ready=0 after 16 accepts; a stall occurs with no sample lost or duplicated; the remaining samples are accepted after the beats drain.
REQ-039 Timeout: one frame, done never asserted -> o_err=1 exactly DONE_TIMEOUT cycles after WAIT_DONE entry; o_frame_cnt=0; the next buffered frame still issues.
REQ-040 Reset mid-SEND: assert i_rst_n=0 after the 3rd beat -> all outputs 0 immediately; after release, no beats until 8 new samples arrive.
REQ-041 Spurious done: pulse i_fft_done during IDLE and during SEND -> no state change, and o_frame_cnt is unchanged.

Source files
------------

// File: rtl/fft_frame_feeder.sv
// Sample feeder for a streaming FFT: buffers two frames and issues
// start / gap / VEC_LEN-beat bursts, then waits for done or times out.
module fft_frame_feeder #(
   parameter int DATA_W       = 32,
   parameter int VEC_LEN      = 8,
   parameter int DONE_TIMEOUT = 1000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_re,
   input  logic [DATA_W-1:0] s_im,
   output logic              o_start,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_re,
   output logic [DATA_W-1:0] o_im,
   input  logic              i_fft_done,
   output logic              o_err,
   output logic [15:0]       o_frame_cnt
);

   localparam int DEPTH = 2 * VEC_LEN;
   localparam int PW    = $clog2(DEPTH);
   localparam int OW    = $clog2(DEPTH + 1);
   localparam int BW    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam int TW    = $clog2(DONE_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      GAP,
      SEND,
      WAIT_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [DATA_W-1:0] r_mem_re [DEPTH];
   logic [DATA_W-1:0] r_mem_im [DEPTH];
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [OW-1:0]     r_occ;
   logic [BW-1:0]     r_beat;
   logic [TW-1:0]     r_tmo;

   logic              r_start;
   logic              r_valid;
   logic [DATA_W-1:0] r_re;
   logic [DATA_W-1:0] r_im;
   logic              r_err;
   logic [15:0]       r_frame_cnt;

   logic              w_acc;
   logic              w_rd;
   logic              w_last_beat;
   logic              w_done;
   logic              w_tmo;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign s_ready     = (r_occ < OW'(DEPTH));
   assign w_acc       = s_valid && s_ready;
   assign w_rd        = (r_state == SEND);
   assign w_last_beat = (r_beat == BW'(VEC_LEN - 1));
   assign w_done      = (r_state == WAIT_DONE) && i_fft_done;
   assign w_tmo       = (r_state == WAIT_DONE) && !i_fft_done
                        && (r_tmo == TW'(DONE_TIMEOUT - 1));

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:      if (r_occ >= OW'(VEC_LEN)) w_next = START;
         START:     w_next = GAP;
         GAP:       w_next = SEND;
         SEND:      if (w_last_beat) w_next = WAIT_DONE;
         WAIT_DONE: if (w_done || w_tmo) w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // Storage carries no reset: pointers alone define valid contents.
   always_ff @(posedge i_clk) begin
      if (w_acc) begin
         r_mem_re[r_wptr] <= s_re;
         r_mem_im[r_wptr] <= s_im;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_occ  <= '0;
      end else begin
         if (w_acc) r_wptr <= f_inc(r_wptr);
         if (w_rd)  r_rptr <= f_inc(r_rptr);
         unique case ({w_acc, w_rd})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_beat <= '0;
         r_tmo  <= '0;
      end else begin
         if (w_rd) r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
         else      r_beat <= '0;
         if (r_state == WAIT_DONE) r_tmo <= r_tmo + 1'b1;
         else                      r_tmo <= '0;
      end
   end

   // Outputs trail the state by one cycle so data is fully registered.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_start     <= 1'b0;
         r_valid     <= 1'b0;
         r_re        <= '0;
         r_im        <= '0;
         r_err       <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_start <= (r_state == START);
         r_valid <= w_rd;
         r_re    <= w_rd ? r_mem_re[r_rptr] : '0;
         r_im    <= w_rd ? r_mem_im[r_rptr] : '0;
         if (w_tmo)  r_err       <= 1'b1;
         if (w_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign o_start     = r_start;
   assign o_valid     = r_valid;
   assign o_re        = r_re;
   assign o_im        = r_im;
   assign o_err       = r_err;
   assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Self-checking bench for fft_frame_feeder: scoreboard of accepted
// samples against emitted beats, plus timing and control scenarios.
module tb_fft_frame_feeder;

   localparam int DW = 32;
   localparam int VL = 8;
   localparam int DT = 1000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_re = '0;
   logic [DW-1:0] s_im = '0;
   logic          o_start;
   logic          o_valid;
   logic [DW-1:0] o_re;
   logic [DW-1:0] o_im;
   logic          i_fft_done = 1'b0;
   logic          o_err;
   logic [15:0]   o_frame_cnt;

   int            n_tests = 0;
   int            n_fail = 0;
   int            seq = 0;
   int            exp_frames = 0;
   int            cyc = 0;
   logic [2*DW-1:0] sb [$];
   logic [31:0]   flt [8] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h40800000, 32'h40A00000, 32'h40C00000,
                              32'h40E00000, 32'h41000000};

   fft_frame_feeder #(
      .DATA_W(DW),
      .VEC_LEN(VL),
      .DONE_TIMEOUT(DT)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .s_re(s_re),
      .s_im(s_im),
      .o_start(o_start),
      .o_valid(o_valid),
      .o_re(o_re),
      .o_im(o_im),
      .i_fft_done(i_fft_done),
      .o_err(o_err),
      .o_frame_cnt(o_frame_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] gen_re(input int i);
      if (i < 8) return flt[i[2:0]];
      return 32'h1000_0000 + i;
   endfunction

   function automatic logic [DW-1:0] gen_im(input int i);
      if (i < 8) return '0;
      return 32'hA5A5_0000 ^ i;
   endfunction

   // Scoreboard: every beat must match the oldest accepted sample.
   always @(negedge clk) begin
      if (rst_n) begin
         n_tests++;
         if (o_valid) begin
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL beat_extra: got re=%h im=%h, want no beat", o_re, o_im);
            end else begin
               logic [2*DW-1:0] e;
               e = sb.pop_front();
               if ({o_re, o_im} !== e)
                  begin n_fail++; $display("FAIL beat_data: got %h_%h want %h", o_re, o_im, e); end
            end
         end else if (o_re !== '0 || o_im !== '0) begin
            n_fail++;
            $display("FAIL idle_zero: got re=%h im=%h want 0", o_re, o_im);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic feed(input int n, input int max_stall, input int done_at,
                       output int last_t, output int stall_at);
      int got;
      int stall;
      got = 0; stall = 0; stall_at = -1; last_t = -1;
      while (got < n) begin
         s_valid = 1'b1;
         s_re = gen_re(seq);
         s_im = gen_im(seq);
         if (s_ready) begin
            sb.push_back({s_re, s_im});
            seq++; got++; stall = 0;
            last_t = cyc + 1;
            if (done_at >= 0) i_fft_done = 1'b0;
         end else begin
            if (stall_at < 0) stall_at = got;
            stall++;
            if (done_at >= 0) i_fft_done = (stall == done_at);
            if (stall > max_stall) begin
               n_tests++; n_fail++;
               $display("FAIL feed_stall: got %0d accepted, want %0d", got, n);
               break;
            end
         end
         tick();
      end
      s_valid = 1'b0; s_re = '0; s_im = '0;
      if (done_at >= 0) i_fft_done = 1'b0;
   endtask

   task automatic observe_frame(input int budget, output int st, output int nst,
                                output int b0, output int bl, output int nb);
      st = -1; nst = 0; b0 = -1; bl = -1; nb = 0;
      for (int i = 0; i < budget && nb < VL; i++) begin
         tick();
         if (o_start) begin nst++; st = cyc; end
         if (o_valid) begin
            if (nb == 0) b0 = cyc;
            bl = cyc;
            nb++;
         end
      end
   endtask

   task automatic pulse_done();
      i_fft_done = 1'b1;
      tick();
      i_fft_done = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_tests++; if (o_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b want 0", o_start); end
      n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", o_valid); end
      n_tests++; if (o_re !== '0) begin n_fail++; $display("FAIL rst_re: got %h want 0", o_re); end
      n_tests++; if (o_im !== '0) begin n_fail++; $display("FAIL rst_im: got %h want 0", o_im); end
      n_tests++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", o_err); end
      n_tests++; if (o_frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", o_frame_cnt); end
      n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", s_ready); end
      rst_n = 1'b1;
   endtask

   task automatic test_single_frame();
      int t, sa, st, nst, b0, bl, nb;
      fork
         feed(VL, 20, -1, t, sa);
         observe_frame(60, st, nst, b0, bl, nb);
      join
      n_tests++; if (nst != 1) begin n_fail++; $display("FAIL sf_nstart: got %0d want 1", nst); end
      n_tests++; if (st != t + 2) begin n_fail++; $display("FAIL sf_start_cyc: got %0d want %0d", st, t + 2); end
      n_tests++; if (b0 != t + 4) begin n_fail++; $display("FAIL sf_first_beat: got %0d want %0d", b0, t + 4); end
      n_tests++; if (bl != t + 3 + VL) begin n_fail++; $display("FAIL sf_last_beat: got %0d want %0d", bl, t + 3 + VL); end
      n_tests++; if (nb != VL) begin n_fail++; $display("FAIL sf_beats: got %0d want %0d", nb, VL); end
      repeat (5) tick();
      pulse_done();
      exp_frames++;
      n_tests++; if (o_frame_cnt !== exp_frames[15:0]) begin n_fail++; $display("FAIL sf_cnt: got %0d want %0d", o_frame_cnt, exp_frames); end
      n_tests++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL sf_err: got %b want 0", o_err); end
      n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL sf_left: got %0d want 0", sb.size()); end
   endtask

   task automatic test_back_to_back();
      int t, sa, st, nst, b0, bl, nb, d;
      fork
         feed(2 * VL, 20, -1, t, sa);
         observe_frame(80, st, nst, b0, bl, nb);
      join
      n_tests++; if (sa != -1) begin n_fail++; $display("FAIL b2b_ready: got stall at %0d want none", sa); end
      n_tests++; if (nb != VL || nst != 1) begin n_fail++; $display("FAIL b2b_f1: got %0d beats %0d starts want %0d 1", nb, nst, VL); end
      repeat (2) tick();
      i_fft_done = 1'b1;
      d = cyc;
      tick();
      i_fft_done = 1'b0;
      observe_frame(40, st, nst, b0, bl, nb);
      n_tests++; if (st != d + 3) begin n_fail++; $display("FAIL b2b_start: got %0d want %0d", st, d + 3); end
      n_tests++; if (b0 != d + 5 || nb != VL) begin n_fail++; $display("FAIL b2b_beats: got b0=%0d n=%0d want %0d %0d", b0, nb, d + 5, VL); end
      tick();
      pulse_done();
      exp_frames += 2;
      n_tests++; if (o_frame_cnt !== exp_frames[15:0]) begin n_fail++; $display("FAIL b2b_cnt: got %0d want %0d", o_frame_cnt, exp_frames); end
      n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_left: got %0d want 0", sb.size()); end
   endtask

   task automatic test_spurious_done();
      int t, sa, st, nst, b0, bl, nb, ns, k;
      ns = 0;
      i_fft_done = 1'b1;
      tick();
      i_fft_done = 1'b0;
      repeat (4) begin tick(); if (o_start) ns++; end
      n_tests++; if (ns != 0) begin n_fail++; $display("FAIL sp_idle_start: got %0d want 0", ns); end
      n_tests++; if (o_frame_cnt !== exp_frames[15:0]) begin n_fail++; $display("FAIL sp_idle_cnt: got %0d want %0d", o_frame_cnt, exp_frames); end
      fork
         feed(VL, 20, -1, t, sa);
         observe_frame(60, st, nst, b0, bl, nb);
         begin
            k = 0;
            while (!o_valid && k < 60) begin tick(); k++; end
            i_fft_done = 1'b1;
            tick();
            i_fft_done = 1'b0;
         end
      join
      n_tests++; if (nb != VL || bl - b0 != VL - 1) begin n_fail++; $display("FAIL sp_send_beats: got n=%0d span=%0d want %0d %0d", nb, bl - b0, VL, VL - 1); end
      n_tests++; if (o_frame_cnt !== exp_frames[15:0]) begin n_fail++; $display("FAIL sp_send_cnt: got %0d want %0d", o_frame_cnt, exp_frames); end
      pulse_done();
      exp_frames++;
      n_tests++; if (o_frame_cnt !== exp_frames[15:0]) begin n_fail++; $display("FAIL sp_done_cnt: got %0d want %0d", o_frame_cnt, exp_frames); end
   endtask

   task automatic test_full_buffer();
      int t, sa, st, nst, b0, bl, nb;
      fork
         feed(VL, 20, -1, t, sa);
         observe_frame(60, st, nst, b0, bl, nb);
      join
      feed(3 * VL, 30, 3, t, sa);
      exp_frames++;
      n_tests++; if (sa != 2 * VL) begin n_fail++; $display("FAIL fb_stall_at: got %0d want %0d", sa, 2 * VL); end
      n_tests++; if (o_frame_cnt !== exp_frames[15:0]) begin n_fail++; $display("FAIL fb_cnt_a: got %0d want %0d", o_frame_cnt, exp_frames); end
      i_fft_done = 1'b1;
      for (int k = 0; k < 200 && sb.size() > 0; k++) tick();
      repeat (3) tick();
      i_fft_done = 1'b0;
      tick();
      exp_frames += 3;
      n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL fb_left: got %0d want 0", sb.size()); end
      n_tests++; if (o_frame_cnt !== exp_frames[15:0]) begin n_fail++; $display("FAIL fb_cnt: got %0d want %0d", o_frame_cnt, exp_frames); end
      n_tests++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL fb_err: got %b want 0", o_err); end
   endtask

   task automatic test_timeout();
      int t, sa, st, nst, b0, bl, nb, k, ec;
      fork
         feed(VL, 20, -1, t, sa);
         observe_frame(60, st, nst, b0, bl, nb);
      join
      feed(VL, 20, -1, t, sa);
      k = 0;
      while (!o_err && k < DT + 50) begin tick(); k++; end
      ec = cyc;
      n_tests++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", o_err); end
      n_tests++; if (ec != bl + DT) begin n_fail++; $display("FAIL to_cyc: got %0d want %0d", ec, bl + DT); end
      n_tests++; if (o_frame_cnt !== exp_frames[15:0]) begin n_fail++; $display("FAIL to_cnt: got %0d want %0d", o_frame_cnt, exp_frames); end
      observe_frame(40, st, nst, b0, bl, nb);
      n_tests++; if (st != ec + 2 || nb != VL) begin n_fail++; $display("FAIL to_next: got st=%0d n=%0d want %0d %0d", st, nb, ec + 2, VL); end
      pulse_done();
      exp_frames++;
      n_tests++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", o_err); end
      n_tests++; if (o_frame_cnt !== exp_frames[15:0]) begin n_fail++; $display("FAIL to_cnt2: got %0d want %0d", o_frame_cnt, exp_frames); end
   endtask

   task automatic test_reset_mid_send();
      int t, sa, st, nst, b0, bl, nb, k, n3;
      n3 = 0;
      fork
         feed(VL, 20, -1, t, sa);
         begin
            k = 0;
            while (n3 < 3 && k < 60) begin tick(); k++; if (o_valid) n3++; end
         end
      join
      n_tests++; if (n3 != 3) begin n_fail++; $display("FAIL rm_beats: got %0d want 3", n3); end
      rst_n = 1'b0;
      #1;
      n_tests++; if ({o_start, o_valid, o_err} !== 3'b000) begin n_fail++; $display("FAIL rm_ctl: got %b want 000", {o_start, o_valid, o_err}); end
      n_tests++; if (o_re !== '0 || o_im !== '0) begin n_fail++; $display("FAIL rm_data: got %h %h want 0", o_re, o_im); end
      n_tests++; if (o_frame_cnt !== 16'd0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL rm_cnt: got %0d rdy=%b want 0 1", o_frame_cnt, s_ready); end
      sb.delete();
      exp_frames = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      fork
         feed(VL - 1, 20, -1, t, sa);
         observe_frame(20, st, nst, b0, bl, nb);
      join
      n_tests++; if (nb != 0 || nst != 0) begin n_fail++; $display("FAIL rm_partial: got %0d beats %0d starts want 0 0", nb, nst); end
      fork
         feed(1, 20, -1, t, sa);
         observe_frame(40, st, nst, b0, bl, nb);
      join
      n_tests++; if (nb != VL || st != t + 2) begin n_fail++; $display("FAIL rm_new: got n=%0d st=%0d want %0d %0d", nb, st, VL, t + 2); end
      pulse_done();
      exp_frames++;
      n_tests++; if (o_frame_cnt !== exp_frames[15:0]) begin n_fail++; $display("FAIL rm_cnt2: got %0d want %0d", o_frame_cnt, exp_frames); end
      n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL rm_left: got %0d want 0", sb.size()); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_spurious_done();
      test_full_buffer();
      test_timeout();
      test_reset_mid_send();
      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
